instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - ADDR_W, 8, instruction-memory byte-address width.
  - DEPTH, 64, maximum instruction words written before full.
REQ-002 Ports, one per line: name, direction, width, meaning.
  - clk, in, 1, single clock; all state updates on its rising edge.
  - rst, in, 1, asynchronous, active-high reset.
  - clear, in, 1, synchronous restart of address and count.
  - req_valid, in, 1, request present.
  - req_ready, out, 1, request accepted when req_valid and req_ready are both high.
  - req_mnem, in, 3, operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 CMP, 101 LSL, 110 LSR, 111 MEM.
  - req_cond, in, 4, condition field.
  - req_s, in, 1, set-flags bit.
  - req_imm_en, in, 1, src2 is immediate.
  - req_load, in, 1, MEM only: 1 = LDR, 0 = STR.
  - req_rn / req_rd / req_rm, in, 4 each, register numbers.
  - req_imm, in, 8, immediate.
  - req_shamt, in, 5, shift amount.
  - imem_we, out, 1, write strobe.
  - imem_addr, out, ADDR_W, byte address.
  - imem_wdata, out, 32, encoded word.
  - imem_ready, in, 1, memory accepts the write this cycle.
  - word_count, out, 7, words written.
  - full, out, 1, word_count equals DEPTH.
  - err_illegal, out, 1, sticky illegal-request flag.

Function
REQ-003 Word format: [31:28] cond, [27:26] op, [25] I, [24:21] cmd, [20] S, [19:16] Rn, [15:12] Rd, [11:0] src2.
REQ-004 Data-processing ops (op=00) use cmd values ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010.
  - I = req_imm_en.
  - Immediate src2 = {4'b0, imm}.
  - Register src2 = {shamt, 2'b00, 1'b0, rm}.
REQ-005 CMP encodes S=1 regardless of req_s, and Rd=0.
REQ-006 LSL/LSR encode cmd 1101, I=0, S=0, Rn=0, src2 = {shamt, sh, 1'b0, rm}, with sh = 00 for LSL and 01 for LSR.
REQ-007 MEM encodes:
  - op = 01.
  - [25] = 0.
  - [24:21] = 1100.
  - [20] = req_load.
  - src2 = {4'b0, imm}.
REQ-008 FSM has four states: IDLE, ENCODE, WRITE, FULL.
  - IDLE: req_ready = 1. An accepted request registers all req_* fields and moves to ENCODE.
  - ENCODE: assembles imem_wdata into a register and moves to WRITE.
  - WRITE: imem_we = 1, with imem_addr and imem_wdata stable. While imem_ready = 0, it stays in WRITE.
  - When imem_ready = 1, address += 4 (wraps modulo 2^ADDR_W) and word_count += 1. Next state is FULL if the new count equals DEPTH, else IDLE.
  - FULL: req_ready = 0, full = 1. Only clear or rst leaves FULL.
REQ-009 req_ready is 0 in every state except IDLE, so at most one request is in flight.
REQ-010 Latency: imem_we first asserts exactly 2 cycles after the accepting edge.
REQ-011 clear has priority over any in-flight write.
  - Next state is IDLE; imem_addr = 0, word_count = 0, full = 0.
  - An in-flight word is dropped.
  - err_illegal is unaffected.
REQ-012 A clear coincident with req_valid in IDLE does not accept the request.
REQ-013 In all states other than WRITE, imem_we = 0.

Reset
REQ-014 While rst is high:
  - state = IDLE.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - word_count = 0, full = 0, err_illegal = 0, all captured fields = 0.
  - req_ready = 0.
REQ-015 req_ready goes high in the first cycle after rst deasserts.
REQ-016 rst asserted mid-WRITE drops the word with no further strobe.

Configuration
REQ-017 Macro ENC_CHECK_EN, when defined, sets err_illegal sticky on acceptance of any of:
  - LSL/LSR with req_imm_en = 1.
  - MEM with req_imm_en = 0.
  - req_cond = 1111.
REQ-018 With ENC_CHECK_EN defined, an illegal request is consumed but not written; the FSM returns from ENCODE to IDLE.
REQ-019 Without ENC_CHECK_EN, err_illegal is tied to 0 and every request is written as encoded.

Structure
REQ-020 Shared package contents:
  - Mnemonic code constants.
  - cmd constants.
  - op constants (DP = 00, MEM = 01).
  - Shift-type constants.
  - FSM state typedef.
  - Field bit-position constants.
  - These are shared with the decoder and the bench.
REQ-021 Combinational word assembly is the single sub-module instr_encoder_pack: captured fields in, 32-bit word out, no state.

Verification
REQ-022 Required directed scenarios (request fields; AL means cond = 1110):
  - ADD, AL, imm_en = 1, rn = 2, rd = 1, imm = 5 -> imem_wdata = 0xE2821005 at imem_addr 0x00, imem_we 2 cycles after accept.
  - SUB, AL, s = 1, rn = 4, rd = 3, rm = 5 -> 0xE0543005.
  - CMP, AL, s = 0, imm_en = 1, rn = 1, imm = 0 -> 0xE3510000.
  - LSL, AL, rd = 0, rm = 1, shamt = 4 -> 0xE1A00201.
  - MEM, AL, load = 1, rn = 3, rd = 2, imm = 8 -> 0xE5932008; with load = 0 -> 0xE5832008.
  - imem_ready held at 0 for 3 cycles -> imem_we stays high with stable data and address increments only once.
  - DEPTH = 4, issue 5 requests -> full = 1 after the 4th, the 5th is stalled with req_ready = 0. A clear then produces imem_addr = 0 and word_count = 0.
  - rst pulsed in WRITE -> no further strobe, all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder, decoder and bench.
// Mnemonic, cmd, op and shift codes, field positions, FSM states.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        MN_ADD = 3'b000,
        MN_SUB = 3'b001,
        MN_AND = 3'b010,
        MN_ORR = 3'b011,
        MN_CMP = 3'b100,
        MN_LSL = 3'b101,
        MN_LSR = 3'b110,
        MN_MEM = 3'b111
    } mnem_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_MEM = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;

    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 26;
    localparam int I_BIT    = 25;
    localparam int CMD_LSB  = 21;
    localparam int S_BIT    = 20;
    localparam int RN_LSB   = 16;
    localparam int RD_LSB   = 12;
    localparam int SRC2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FULL   = 2'd3
    } state_e;

    typedef struct packed {
        mnem_e      mnem;
        logic [3:0] cond;
        logic       s;
        logic       imm_en;
        logic       load;
        logic [3:0] rn;
        logic [3:0] rd;
        logic [3:0] rm;
        logic [7:0] imm;
        logic [4:0] shamt;
    } req_t;

    function automatic logic is_illegal(req_t r);
        logic shift_imm;
        logic mem_reg;
        shift_imm = (r.mnem == MN_LSL || r.mnem == MN_LSR) && r.imm_en;
        mem_reg   = (r.mnem == MN_MEM) && !r.imm_en;
        return shift_imm || mem_reg || (r.cond == COND_NV);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational assembly of one 32-bit instruction word
// from a captured request; holds no state.
import instr_encoder_pkg::*;

module instr_encoder_pack (
    input  req_t        i_req,
    output logic [31:0] o_word
);

    logic [1:0]  w_op;
    logic        w_i;
    logic [3:0]  w_cmd;
    logic        w_s;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [11:0] w_src2;
    logic [11:0] w_src2_imm;
    logic [11:0] w_src2_reg;

    assign w_src2_imm = {4'b0000, i_req.imm};
    assign w_src2_reg = {i_req.shamt, SH_LSL, 1'b0, i_req.rm};

    always_comb begin
        w_op   = OP_DP;
        w_i    = i_req.imm_en;
        w_cmd  = CMD_ADD;
        w_s    = i_req.s;
        w_rn   = i_req.rn;
        w_rd   = i_req.rd;
        w_src2 = i_req.imm_en ? w_src2_imm : w_src2_reg;
        unique case (i_req.mnem)
            MN_ADD: w_cmd = CMD_ADD;
            MN_SUB: w_cmd = CMD_SUB;
            MN_AND: w_cmd = CMD_AND;
            MN_ORR: w_cmd = CMD_ORR;
            MN_CMP: begin
                w_cmd = CMD_CMP;
                w_s   = 1'b1;
                w_rd  = 4'd0;
            end
            MN_LSL, MN_LSR: begin
                w_cmd  = CMD_MOV;
                w_i    = 1'b0;
                w_s    = 1'b0;
                w_rn   = 4'd0;
                w_src2 = {i_req.shamt,
                          (i_req.mnem == MN_LSR) ? SH_LSR : SH_LSL,
                          1'b0, i_req.rm};
            end
            MN_MEM: begin
                w_op   = OP_MEM;
                w_i    = 1'b0;
                w_cmd  = CMD_MEM;
                w_s    = i_req.load;
                w_src2 = w_src2_imm;
            end
        endcase
    end

    always_comb begin
        o_word                     = '0;
        o_word[COND_LSB +: 4]      = i_req.cond;
        o_word[OP_LSB +: 2]        = w_op;
        o_word[I_BIT]              = w_i;
        o_word[CMD_LSB +: 4]       = w_cmd;
        o_word[S_BIT]              = w_s;
        o_word[RN_LSB +: 4]        = w_rn;
        o_word[RD_LSB +: 4]        = w_rd;
        o_word[SRC2_LSB +: 12]     = w_src2;
    end

endmodule

// File: rtl/instr_encoder.sv
// Request-driven instruction encoder writing words to instruction memory.
// Optional legality checking is enabled by defining ENC_CHECK_EN.
import instr_encoder_pkg::*;

module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_mnem,
    input  logic [3:0]        req_cond,
    input  logic              req_s,
    input  logic              req_imm_en,
    input  logic              req_load,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [7:0]        req_imm,
    input  logic [4:0]        req_shamt,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic [6:0]        word_count,
    output logic              full,
    output logic              err_illegal
);

    state_e            r_state;
    state_e            w_next;
    req_t              r_req;
    req_t              w_req;
    logic [31:0]       r_word;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_count;
    logic [6:0]        w_count_inc;
    logic              w_accept;
    logic              w_done;

    assign w_req = '{mnem: mnem_e'(req_mnem), cond: req_cond,
                     s: req_s, imm_en: req_imm_en,
                     load: req_load, rn: req_rn, rd: req_rd,
                     rm: req_rm, imm: req_imm, shamt: req_shamt};

    instr_encoder_pack u_pack (
        .i_req  (r_req),
        .o_word (w_word)
    );

    assign req_ready   = (r_state == ST_IDLE) && !clear && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_done      = (r_state == ST_WRITE) && imem_ready;
    assign w_count_inc = r_count + 7'd1;

    assign imem_we     = (r_state == ST_WRITE) && !rst;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_word;
    assign word_count  = r_count;
    assign full        = (r_state == ST_FULL);

`ifdef ENC_CHECK_EN
    logic r_illegal;
    logic r_err;

    assign err_illegal = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= is_illegal(w_req);
            if (is_illegal(w_req)) r_err <= 1'b1;
        end
    end
`else
    logic r_illegal;

    assign r_illegal   = 1'b0;
    assign err_illegal = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   if (w_accept) w_next = ST_ENCODE;
                ST_ENCODE: w_next = r_illegal ? ST_IDLE : ST_WRITE;
                ST_WRITE: begin
                    if (imem_ready)
                        w_next = (w_count_inc == 7'(DEPTH)) ? ST_FULL : ST_IDLE;
                end
                ST_FULL:   w_next = ST_FULL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_req <= w_req;
            if (r_state == ST_ENCODE) r_word <= w_word;
            // clear wins over a completing write so the word is dropped
            if (clear) begin
                r_addr  <= '0;
                r_count <= '0;
            end else if (w_done) begin
                r_addr  <= r_addr + ADDR_W'(4);
                r_count <= w_count_inc;
            end
        end
    end

endmodule
